// File: rtl/qs_fetch.sv
// qs_fetch: instruction fetch with opcode predecode and a 2-entry output buffer.
module qs_fetch #(
    parameter int PC_W = 8,
    parameter int INST_W = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic              resume,
    input  logic              redirect_vld,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              imem_en,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_vld,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc,
    input  logic              inst_rdy,
    output logic              halted
);
    typedef enum logic [1:0] {IDLE, RUN, WAIT_BR, HALT} state_t;
    state_t state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, ipc_q;
    logic inflight_q, kill_q, kill_d, rd_q, wr;
    logic [1:0] count_q, count_d;
    logic [INST_W-1:0] bi_q [2];
    logic [PC_W-1:0] bp_q [2];
    logic pop, redir, ret, stop_br, stop_wt, stop;
    logic [3:0] op;
    logic [2:0] credit;

    assign op = imem_rdata[INST_W-1 -: 4];
    assign pop = inst_vld & inst_rdy;
    assign wr = rd_q ^ count_q[0];
    assign inst_vld = count_q != 2'd0;
    assign inst = bi_q[rd_q];
    assign inst_pc = bp_q[rd_q];
    assign imem_addr = pc_q;
    assign halted = (state_q == IDLE) | (state_q == HALT);

    always_comb begin
        redir = redirect_vld & (state_q != IDLE);
        ret = inflight_q & ~kill_q & ~redir;
        stop_br = ret & ((op == 4'b0001) | (op == 4'b1100));
        stop_wt = ret & (op == 4'b1111) & ~imem_rdata[INST_W-5];
        stop = (state_q == RUN) & (stop_br | stop_wt);
        // reads in flight count as occupied slots so the buffer cannot overflow
        credit = 3'(count_q) + 3'(inflight_q) - 3'(pop);
        imem_en = (state_q == RUN) & ~redirect_vld & (credit < 3'd2);
        kill_d = imem_en & stop;
        state_d = state_q;
        if (redir) state_d = RUN;
        else if (state_q == IDLE && start) state_d = RUN;
        else if (state_q == HALT && resume) state_d = RUN;
        else if (stop) state_d = stop_br ? WAIT_BR : HALT;
        // on a stop the PC rewinds to the word after the stopping one, ready for resume
        pc_d = redir ? redirect_pc : stop ? ipc_q + PC_W'(1) : imem_en ? pc_q + PC_W'(1) : pc_q;
        count_d = redir ? 2'd0 : count_q - 2'(pop) + 2'(ret);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            pc_q <= RESET_PC;
            ipc_q <= '0;
            inflight_q <= 1'b0;
            kill_q <= 1'b0;
            count_q <= 2'd0;
            rd_q <= 1'b0;
            bi_q[0] <= '0;
            bi_q[1] <= '0;
            bp_q[0] <= '0;
            bp_q[1] <= '0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            ipc_q <= pc_q;
            inflight_q <= imem_en;
            kill_q <= kill_d;
            count_q <= count_d;
            rd_q <= rd_q ^ pop;
            if (ret) begin
                bi_q[wr] <= imem_rdata;
                bp_q[wr] <= ipc_q;
            end
        end
    end
endmodule

// File: tb/tb_qs_fetch.sv
// tb_qs_fetch: queue-based reference model checked every cycle, plus directed literal checks.
module tb_qs_fetch;
    logic clk = 0, arst_n = 0, start = 0, resume = 0, redirect_vld = 0, inst_rdy = 1;
    logic [7:0] redirect_pc = '0, imem_addr, inst_pc;
    logic imem_en, inst_vld, halted;
    logic [15:0] imem_rdata = '0, inst;
    logic [15:0] mem [256];
    int n_tests = 0, n_fail = 0;

    qs_fetch dut (
        .clk(clk), .arst_n(arst_n), .start(start), .resume(resume),
        .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .inst_vld(inst_vld), .inst(inst), .inst_pc(inst_pc),
        .inst_rdy(inst_rdy), .halted(halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] rand_word();
        int r = $urandom_range(0, 99);
        logic [11:0] p = 12'($urandom);
        logic [3:0] op = 4'($urandom_range(0, 13));
        if (r < 6) return {4'h1, p};
        if (r < 9) return {4'hC, p};
        if (r < 13) return {4'hF, 1'b0, p[10:0]};
        if (r < 18) return {4'hF, 1'b1, p[10:0]};
        if (op == 4'h1) op = 4'hD;
        if (op == 4'hC) op = 4'hE;
        return {op, p};
    endfunction

    // Model: q holds the PCs buffered for decode in order; fetch proceeds in program order
    // and stops after a branch or WAIT word comes back, the read issued alongside is dropped.
    bit m_started, m_brw, m_halt, m_infl, m_kill, m_red, m_pop, m_en, m_ret, m_stop, m_was_halt;
    logic [7:0] m_fpc, m_rpc, m_ipc;
    logic [15:0] m_w;
    logic [7:0] q [$];

    always @(negedge clk) begin
        if (!arst_n) begin
            m_started = 0; m_brw = 0; m_halt = 0; m_infl = 0; m_kill = 0;
            m_fpc = 8'h00; m_rpc = 8'h00; m_ipc = 8'h00;
            q.delete();
            chk("rst_vld", inst_vld, 0);
            chk("rst_en", imem_en, 0);
            chk("rst_addr", imem_addr, 0);
            chk("rst_inst", inst, 0);
            chk("rst_pc", inst_pc, 0);
            chk("rst_halted", halted, 1);
        end else begin
            m_red = redirect_vld && m_started;
            m_pop = (q.size() != 0) && inst_rdy;
            m_en = m_started && !m_brw && !m_halt && !redirect_vld &&
                   (q.size() - int'(m_pop) + int'(m_infl) < 2);
            chk("inst_vld", inst_vld, q.size() != 0);
            if (q.size() != 0) begin
                chk("inst_pc", inst_pc, q[0]);
                chk("inst", inst, mem[q[0]]);
            end
            chk("halted", halted, !m_started || m_halt);
            chk("imem_en", imem_en, m_en);
            if (m_en) chk("imem_addr", imem_addr, m_fpc);
            m_was_halt = m_halt;
            m_stop = 0;
            if (m_pop) void'(q.pop_front());
            m_ret = m_infl && !m_kill && !m_red;
            if (m_ret) begin
                q.push_back(m_ipc);
                m_w = mem[m_ipc];
                if (m_w[15:12] == 4'h1 || m_w[15:12] == 4'hC) begin
                    m_brw = 1; m_stop = 1;
                end else if (m_w[15:12] == 4'hF && !m_w[11]) begin
                    m_halt = 1; m_stop = 1; m_rpc = m_ipc + 8'd1;
                end
            end
            m_infl = m_en;
            m_kill = m_en && m_stop;
            m_ipc = m_fpc;
            if (m_en) m_fpc = m_fpc + 8'd1;
            if (m_red) begin
                q.delete(); m_brw = 0; m_halt = 0; m_fpc = redirect_pc;
            end else if (!m_started && start) m_started = 1;
            else if (m_was_halt && resume) begin
                m_halt = 0; m_fpc = m_rpc;
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {8'h00, 8'(i)};
        mem[8'h04] = 16'h1004;
        mem[8'h44] = 16'hF844;
        mem[8'h47] = 16'hF047;
        repeat (3) @(posedge clk);
        #3 arst_n = 1;
        repeat (2) begin
            @(negedge clk);
            chk("idle_halted", halted, 1);
            chk("idle_en", imem_en, 0);
        end
        for (int c = 0; c < 46; c++) begin
            @(posedge clk); #1;
            start = (c == 0);
            redirect_vld = (c == 9) || (c == 23) || (c == 39);
            redirect_pc = (c == 9) ? 8'h20 : (c == 23) ? 8'h40 : 8'hFE;
            resume = (c == 35);
            inst_rdy = !((c >= 13 && c <= 18) || (c >= 21 && c <= 23));
            @(negedge clk);
            case (c)
                1: begin chk("c1_en", imem_en, 1); chk("c1_addr", imem_addr, 0); chk("c1_vld", inst_vld, 0); end
                3: begin chk("c3_vld", inst_vld, 1); chk("c3_pc", inst_pc, 0); end
                6: begin chk("c6_en", imem_en, 1); chk("c6_addr", imem_addr, 5); end
                7: begin chk("c7_pc", inst_pc, 4); chk("c7_inst", inst, 16'h1004); chk("c7_en", imem_en, 0); end
                8: begin chk("c8_vld", inst_vld, 0); chk("c8_en", imem_en, 0); chk("c8_halted", halted, 0); end
                9: chk("c9_en", imem_en, 0);
                10: begin chk("c10_en", imem_en, 1); chk("c10_addr", imem_addr, 8'h20); end
                12: begin chk("c12_vld", inst_vld, 1); chk("c12_pc", inst_pc, 8'h20); end
                13: begin chk("c13_pc", inst_pc, 8'h21); chk("c13_en", imem_en, 0); end
                18: begin chk("c18_pc", inst_pc, 8'h21); chk("c18_en", imem_en, 0); end
                19: begin chk("c19_en", imem_en, 1); chk("c19_addr", imem_addr, 8'h23); chk("c19_pc", inst_pc, 8'h21); end
                20: chk("c20_pc", inst_pc, 8'h22);
                21: begin chk("c21_pc", inst_pc, 8'h23); chk("c21_en", imem_en, 0); end
                24: begin chk("c24_vld", inst_vld, 0); chk("c24_en", imem_en, 1); chk("c24_addr", imem_addr, 8'h40); end
                26: chk("c26_pc", inst_pc, 8'h40);
                30: begin chk("c30_pc", inst_pc, 8'h44); chk("c30_inst", inst, 16'hF844); end
                32: begin chk("c32_addr", imem_addr, 8'h48); chk("c32_halted", halted, 0); end
                33: begin chk("c33_halted", halted, 1); chk("c33_en", imem_en, 0); chk("c33_pc", inst_pc, 8'h47); end
                34: chk("c34_vld", inst_vld, 0);
                35: chk("c35_halted", halted, 1);
                36: begin chk("c36_halted", halted, 0); chk("c36_en", imem_en, 1); chk("c36_addr", imem_addr, 8'h48); end
                38: chk("c38_pc", inst_pc, 8'h48);
                40: chk("c40_addr", imem_addr, 8'hFE);
                41: chk("c41_addr", imem_addr, 8'hFF);
                42: begin chk("c42_addr", imem_addr, 8'h00); chk("c42_pc", inst_pc, 8'hFE); end
                44: chk("c44_pc", inst_pc, 8'h00);
                default: ;
            endcase
        end
        @(posedge clk); #3 arst_n = 0;
        #1;
        chk("arst_en", imem_en, 0);
        chk("arst_addr", imem_addr, 0);
        chk("arst_vld", inst_vld, 0);
        chk("arst_inst", inst, 0);
        chk("arst_pc", inst_pc, 0);
        chk("arst_halted", halted, 1);
        for (int i = 0; i < 256; i++) mem[i] = rand_word();
        inst_rdy = 1;
        repeat (3) @(posedge clk);
        #3 arst_n = 1;
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        @(negedge clk);
        chk("restart_en", imem_en, 1);
        chk("restart_addr", imem_addr, 0);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            inst_rdy = $urandom_range(0, 99) < 75;
            redirect_vld = $urandom_range(0, 99) < 4;
            redirect_pc = 8'($urandom);
            resume = $urandom_range(0, 99) < 8;
            start = $urandom_range(0, 99) < 2;
        end
        @(posedge clk); #1;
        redirect_vld = 0; resume = 0; start = 0; inst_rdy = 1;
        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/qs_fetch.md
Name: qs_fetch

Overview:
- Instruction fetch stage directly upstream of the qs instruction decoder.
- Owns the program counter and issues reads to a synchronous instruction memory.
- Predecodes the opcode of each returned word so that it stops fetching after a control transfer or WAIT.
- Delivers instructions with their PC to decode over a valid/ready interface, through a 2-entry buffer.

Parameters:
PC_W, 8, program-counter width (matches pc_t)
INST_W, 16, instruction width (opcode[15:12], payload[11:0])
RESET_PC, 0, PC loaded on reset

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous active-low reset
start  in  1  pulse; leave IDLE and begin fetching at the current PC
resume  in  1  pulse; leave HALT and fetch at PC of WAIT + 1
redirect_vld  in  1  execute resolved a JCC/CALL/RET, or a flush
redirect_pc  in  PC_W  new fetch PC (execute supplies PC+1 for a not-taken JCC)
imem_en  out  1  instruction memory read strobe
imem_addr  out  PC_W  read address
imem_rdata  in  INST_W  read data, valid exactly one cycle after imem_en
inst_vld  out  1  instruction available to decode
inst  out  INST_W  instruction word
inst_pc  out  PC_W  PC of inst
inst_rdy  in  1  decode accepts; transfer on inst_vld & inst_rdy
halted  out  1  state is IDLE or HALT

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on arst_n. All state is cleared on arst_n low.
- Values while arst_n is low:
  - state=IDLE, pc=RESET_PC.
  - Buffer empty; in-flight and kill flags 0.
  - imem_en=0, imem_addr=RESET_PC.
  - inst_vld=0, inst=0, inst_pc=0.
  - halted=1.
- States: IDLE, RUN, WAIT_BR, HALT.
  - IDLE->RUN on start.
  - RUN->WAIT_BR when a returned word has opcode JCC (4'b0001) or CRET (4'b1100).
  - RUN->HALT when a returned word has opcode CNTRL (4'b1111) with bit11=0 (WAIT). EMIT (bit11=1) does not stop fetch.
  - WAIT_BR->RUN on redirect_vld.
  - HALT->RUN on resume; pc=PC of WAIT+1.
  - redirect_vld in any state except IDLE forces RUN with pc=redirect_pc.
  - start/resume in a non-matching state are ignored.
- Issue rule:
  - imem_en = (state==RUN) & !redirect_vld & (count - pop + inflight < 2), where pop = inst_vld & inst_rdy.
  - imem_addr = pc. pc increments by 1 on each issue and wraps 0xFF->0x00.
- Return path:
  - The cycle after an issue, imem_rdata is written into the buffer with its PC, unless that read is killed.
  - inst_vld is registered: a word returned in cycle t is visible at t+1.
  - Start-to-first-inst latency: start at t -> imem_en at t+1 -> inst_vld at t+3.
- Sustained throughput is 1 instruction/cycle with inst_rdy held high.
- Speculation kill: when a returned word moves state to WAIT_BR or HALT, any read issued in that same cycle is marked killed. Its data is discarded next cycle.
- Redirect handling:
  - Empties the buffer next cycle.
  - Kills the outstanding read.
  - Drops any word returning in that cycle, including a control word; redirect wins.
  - Issues the first read at redirect_pc one cycle later.
- Buffer:
  - FIFO order; never overflows (credit rule above); never outputs duplicates.
  - inst/inst_pc hold their values while inst_vld & !inst_rdy.
- Reset asserted mid-operation returns every output to its reset value immediately. Outstanding memory data is ignored after release.

Test Plan:
- NOPs at 0..3, start at cycle 5 -> imem_addr 0,1,2,3 on cycles 6..9; inst_vld first at cycle 8 with inst_pc=0; one inst per cycle thereafter.
- inst_rdy low for 6 cycles in RUN -> buffer holds 2, imem_en low after 2 outstanding; on release, PCs delivered in order with no gap, loss or duplicate.
- JCC at pc 4 -> pc 4 delivered, the fetch of pc 5 is discarded, state WAIT_BR, imem_en low; redirect_pc=0x20 -> next imem_addr=0x20, next inst_pc=0x20.
- WAIT at pc 7 -> halted=1, no further fetch, pc 7 delivered; resume -> imem_addr=8, halted=0.
- Buffer full with inst_rdy low, redirect_vld with 0x40 -> inst_vld=0 next cycle; next delivered inst_pc=0x40.
- pc at 0xFE in RUN -> addresses 0xFE, 0xFF, 0x00. arst_n pulsed low mid-stream -> all outputs at reset values asynchronously; start after release fetches from RESET_PC.
